// File: rtl/div_arb_pkg.sv
// div_arb_pkg: shared definitions for the divider-sharing arbiter.
//   DATA_W       operand / result width
//   DZ_QUOTIENT  quotient reported for a zero divisor
//   state_e      controller states with fixed encodings
//   is_zero      helper used for the divide-by-zero short-circuit
package div_arb_pkg;

    localparam int DATA_W = 32;
    localparam logic [DATA_W-1:0] DZ_QUOTIENT = 32'hFFFF_FFFF;

    // Fixed encodings kept as plain constants so older tooling and
    // debug scripts can decode the state register directly.
    localparam logic [1:0] IDLE_ENC = 2'd0;
    localparam logic [1:0] LOAD_ENC = 2'd1;
    localparam logic [1:0] BUSY_ENC = 2'd2;
    localparam logic [1:0] DONE_ENC = 2'd3;

    typedef enum logic [1:0] {
        IDLE = IDLE_ENC,
        LOAD = LOAD_ENC,
        BUSY = BUSY_ENC,
        DONE = DONE_ENC
    } state_e;

    function automatic logic is_zero(input logic [DATA_W-1:0] v);
        return (v == {DATA_W{1'b0}});
    endfunction

endpackage

// File: rtl/division_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req    request vector, bit i = requester i
//   ptr    index with the highest priority this cycle
//   grant  one-hot of the first set req bit at or above ptr (with wrap)
//   idx    binary index of the granted requester (0 when none)
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    // Walk the requesters starting at ptr; the first hit wins and masks the rest.
    always_comb begin
        int   cand;
        logic found;
        logic hit;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        hit   = 1'b0;
        cand  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand        = int'(ptr) + k;
            cand        = (cand >= NUM_REQ) ? (cand - NUM_REQ) : cand;
            hit         = !found && req[cand];
            grant[cand] = grant[cand] | hit;
            idx         = hit ? cand[IDX_W-1:0] : idx;
            found       = found | hit;
        end
    end

endmodule

// File: rtl/division_arbiter.sv
// division_arbiter: shares one iterative divider between NUM_REQ requesters.
//   clock, reset_n        rising-edge clock, synchronous active-low reset
//   req_valid/req_ready   per-requester handshake (req_ready one-hot, IDLE only)
//   req_a, req_b          packed operands, slice i belongs to requester i
//   resp_valid/resp_ready result handshake; resp_id/q/r/dz held until accepted
//   div_start             one-cycle start pulse to the external divider
//   div_a, div_b          operands, stable from grant until the next grant
//   div_q, div_r          divider results, valid DIV_LATENCY edges after start
module division_arbiter
    import div_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DIV_LATENCY = 32,
    localparam int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [DATA_W*NUM_REQ-1:0] req_a,
    input  logic [DATA_W*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [IDX_W-1:0]          resp_id,
    output logic [DATA_W-1:0]         resp_q,
    output logic [DATA_W-1:0]         resp_r,
    output logic                      resp_dz,
    output logic                      div_start,
    output logic [DATA_W-1:0]         div_a,
    output logic [DATA_W-1:0]         div_b,
    input  logic [DATA_W-1:0]         div_q,
    input  logic [DATA_W-1:0]         div_r
);

    localparam int CNT_W = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_LATENCY - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    state_e              state_r;
    logic [IDX_W-1:0]    ptr_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                resp_valid_r;
    logic [IDX_W-1:0]    resp_id_r;
    logic [DATA_W-1:0]   resp_q_r;
    logic [DATA_W-1:0]   resp_r_r;
    logic                resp_dz_r;
    logic                div_start_r;
    logic [DATA_W-1:0]   div_a_r;
    logic [DATA_W-1:0]   div_b_r;

    logic [NUM_REQ-1:0]  grant_s;
    logic [IDX_W-1:0]    gidx_s;
    logic                hs_s;
    logic [DATA_W-1:0]   sel_a_s;
    logic [DATA_W-1:0]   sel_b_s;
    logic [IDX_W-1:0]    ptr_next_s;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req   (req_valid),
        .ptr   (ptr_r),
        .grant (grant_s),
        .idx   (gidx_s)
    );

    // Grants are offered only while idle and never while reset is held.
    always_comb begin
        if (reset_n && (state_r == IDLE)) begin
            req_ready = grant_s;
        end else begin
            req_ready = '0;
        end
    end

    assign hs_s       = |(req_valid & req_ready);
    assign ptr_next_s = (gidx_s == IDX_LAST) ? {IDX_W{1'b0}} : (gidx_s + IDX_W'(1));

    // Operand mux for the granted requester.
    always_comb begin
        sel_a_s = '0;
        sel_b_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_a_s = (gidx_s == IDX_W'(i)) ? req_a[i*DATA_W +: DATA_W] : sel_a_s;
            sel_b_s = (gidx_s == IDX_W'(i)) ? req_b[i*DATA_W +: DATA_W] : sel_b_s;
        end
    end

    // Controller: grant, start pulse, latency count, capture, result hold.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            ptr_r        <= '0;
            cnt_r        <= '0;
            resp_valid_r <= 1'b0;
            resp_id_r    <= '0;
            resp_q_r     <= '0;
            resp_r_r     <= '0;
            resp_dz_r    <= 1'b0;
            div_start_r  <= 1'b0;
            div_a_r      <= '0;
            div_b_r      <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (hs_s) begin
                        div_a_r   <= sel_a_s;
                        div_b_r   <= sel_b_s;
                        resp_id_r <= gidx_s;
                        ptr_r     <= ptr_next_s;
                        if (is_zero(sel_b_s)) begin
                            // Zero divisor never touches the divider.
                            resp_q_r     <= DZ_QUOTIENT;
                            resp_r_r     <= sel_a_s;
                            resp_dz_r    <= 1'b1;
                            resp_valid_r <= 1'b1;
                            state_r      <= DONE;
                        end else begin
                            div_start_r <= 1'b1;
                            state_r     <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    div_start_r <= 1'b0;
                    cnt_r       <= '0;
                    state_r     <= BUSY;
                end
                BUSY: begin
                    // cnt_r == CNT_LAST on the DIV_LATENCY-th edge after start.
                    if (cnt_r == CNT_LAST) begin
                        resp_q_r     <= div_q;
                        resp_r_r     <= div_r;
                        resp_dz_r    <= 1'b0;
                        resp_valid_r <= 1'b1;
                        state_r      <= DONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid_r <= 1'b0;
                        state_r      <= IDLE;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    div_start_r  <= 1'b0;
                    resp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign resp_valid = resp_valid_r;
    assign resp_id    = resp_id_r;
    assign resp_q     = resp_q_r;
    assign resp_r     = resp_r_r;
    assign resp_dz    = resp_dz_r;
    assign div_start  = div_start_r;
    assign div_a      = div_a_r;
    assign div_b      = div_b_r;

endmodule

// File: tb/tb_division_arbiter.sv
// Behavioural iterative divider: results appear LAT-1 edges after the start
// edge (so they are sampled on the LAT-th edge); garbage before that.
module Division #(
    parameter int LAT = 32
) (
    input  logic        clock,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] q,
    output logic [31:0] r
);
    logic [31:0] a_h, b_h;
    int cnt = 0;

    always @(posedge clock) begin
        if (start) begin
            a_h <= a;
            b_h <= b;
            cnt <= 1;
            q   <= 32'hBAD0_BAD0;
            r   <= 32'hBAD1_BAD1;
        end else if (cnt != 0) begin
            if (cnt == LAT - 1) begin
                q   <= (b_h == 32'd0) ? 32'hFFFF_FFFF : a_h / b_h;
                r   <= (b_h == 32'd0) ? a_h : a_h % b_h;
                cnt <= 0;
            end else begin
                cnt <= cnt + 1;
            end
        end
    end
endmodule

module tb_division_arbiter;
    localparam int N     = 4;
    localparam int L     = 32;
    localparam int BOUND = 200;

    logic            clock = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req_valid;
    logic [32*N-1:0] req_a, req_b;
    logic [N-1:0]    req_ready;
    logic            resp_valid, resp_ready;
    logic [1:0]      resp_id;
    logic [31:0]     resp_q, resp_r;
    logic            resp_dz;
    logic            div_start;
    logic [31:0]     div_a, div_b, div_q, div_r;

    division_arbiter #(.NUM_REQ(N), .DIV_LATENCY(L)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_q(resp_q), .resp_r(resp_r), .resp_dz(resp_dz),
        .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .div_q(div_q), .div_r(div_r)
    );

    Division #(.LAT(L)) u_div (
        .clock(clock), .start(div_start), .a(div_a), .b(div_b), .q(div_q), .r(div_r)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          id;
        logic [31:0] a, b, q, r;
        logic        dz;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] q, r;
        logic        dz;
    } exp_t;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   ds_cnt = 0;
    int   cyc    = 0;
    exp_t sb[$];
    int   grant_log[$];
    int   grant_cyc[$];
    exp_t e;
    int   g;
    logic [31:0] ga, gb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: actual=timeout required=event within %0d cycles", name, BOUND);
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard: push the model result on each grant, pop on each response.
    always @(negedge clock) begin
        if (reset_n) begin
            if (div_start) ds_cnt++;
            if (|(req_valid & req_ready)) begin
                chk("grant_onehot", 32'($onehot(req_valid & req_ready)), 32'd1);
                g = 0;
                for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) g = i;
                ga = req_a[g*32 +: 32];
                gb = req_b[g*32 +: 32];
                e.id = g;
                e.dz = (gb == 32'd0);
                e.q  = e.dz ? 32'hFFFF_FFFF : ga / gb;
                e.r  = e.dz ? ga : ga % gb;
                sb.push_back(e);
                grant_log.push_back(g);
                grant_cyc.push_back(cyc);
            end
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    timeout("sb_unexpected_response");
                end else begin
                    e = sb.pop_front();
                    chk("sb_id", 32'(resp_id), 32'(e.id));
                    chk("sb_q", resp_q, e.q);
                    chk("sb_r", resp_r, e.r);
                    chk("sb_dz", 32'(resp_dz), 32'(e.dz));
                end
            end
        end
    end

    initial begin
        repeat (30000) @(posedge clock);
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic drive_req(input int id, input logic [31:0] a, input logic [31:0] b);
        req_valid[id]      = 1'b1;
        req_a[id*32 +: 32] = a;
        req_b[id*32 +: 32] = b;
    endtask

    // Returns just after the handshake edge with the request withdrawn.
    task automatic wait_grant(input int id, input string name);
        int n = 0;
        @(negedge clock);
        while (!req_ready[id] && n < BOUND) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready[id]) begin
            timeout(name);
            req_valid[id] = 1'b0;
        end else begin
            @(posedge clock);
            #1;
            req_valid[id] = 1'b0;
        end
    endtask

    // Counts edges after the handshake edge until resp_valid is seen.
    task automatic wait_resp(output int n, input string name);
        n = 0;
        @(negedge clock);
        while (!resp_valid && n < BOUND) begin
            @(posedge clock);
            n++;
            @(negedge clock);
        end
        if (!resp_valid) timeout(name);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        @(posedge clock);
        #1;
        while ((sb.size() != 0 || resp_valid) && n < BOUND) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (sb.size() != 0 || resp_valid) timeout(name);
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({p, "_resp_id"}, 32'(resp_id), 32'd0);
        chk({p, "_resp_q"}, resp_q, 32'd0);
        chk({p, "_resp_r"}, resp_r, 32'd0);
        chk({p, "_resp_dz"}, 32'(resp_dz), 32'd0);
        chk({p, "_div_start"}, 32'(div_start), 32'd0);
        chk({p, "_div_a"}, div_a, 32'd0);
        chk({p, "_div_b"}, div_b, 32'd0);
        chk({p, "_req_ready"}, 32'(req_ready), 32'd0);
    endtask

    task automatic do_one(input vec_t v);
        int n;
        ds_cnt = 0;
        @(posedge clock);
        #1;
        drive_req(v.id, v.a, v.b);
        wait_grant(v.id, "vec_grant");
        wait_resp(n, "vec_resp");
        chk("vec_latency", 32'(n), v.dz ? 32'd0 : 32'(L + 1));
        chk("vec_q", resp_q, v.q);
        chk("vec_r", resp_r, v.r);
        chk("vec_id", 32'(resp_id), 32'(v.id));
        chk("vec_dz", 32'(resp_dz), 32'(v.dz));
        chk("vec_div_a", div_a, v.a);
        chk("vec_div_b", div_b, v.b);
        @(posedge clock);
        #1;
        chk("vec_start_cycles", 32'(ds_cnt), v.dz ? 32'd0 : 32'd1);
        chk("vec_resp_released", 32'(resp_valid), 32'd0);
    endtask

    initial begin
        vec_t vecs[8];
        int n;
        logic [31:0] hq, hr, hid, hdz;

        vecs[0] = '{0, 32'd7,          32'd3,          32'd2,          32'd1,          1'b0};
        vecs[1] = '{2, 32'd100,        32'd0,          32'hFFFF_FFFF,  32'd100,        1'b1};
        vecs[2] = '{1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0};
        vecs[3] = '{3, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
        vecs[4] = '{0, 32'd1000000,    32'd1000,       32'd1000,       32'd0,          1'b0};
        vecs[5] = '{2, 32'd5,          32'd9,          32'd0,          32'd5,          1'b0};
        vecs[6] = '{1, 32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0,          1'b1};
        vecs[7] = '{3, 32'hDEAD_BEEF,  32'h10,         32'h0DEA_DBEE,  32'hF,          1'b0};

        // Reset with every requester asking: grants must stay forced off.
        reset_n    = 1'b0;
        resp_ready = 1'b1;
        req_valid  = '1;
        req_a      = {4{32'h1234_5678}};
        req_b      = {4{32'd3}};
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk_reset("rst");
        @(posedge clock);
        #1;
        req_valid = '0;
        reset_n   = 1'b1;

        for (int i = 0; i < 8; i++) do_one(vecs[i]);
        wait_drain("vec_drain");

        // Round-robin from ptr 0 with everyone requesting continuously.
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        sb.delete();
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        grant_log.delete();
        grant_cyc.delete();
        for (int i = 0; i < N; i++) drive_req(i, 32'(100 + i), 32'd7);
        n = 0;
        while (grant_log.size() < 5 && n < 5 * BOUND) begin
            @(posedge clock);
            #1;
            n++;
        end
        req_valid = '0;
        if (grant_log.size() < 5) begin
            timeout("rr_grants");
        end else begin
            for (int k = 0; k < 5; k++) chk("rr_order", 32'(grant_log[k]), 32'(k % N));
            for (int k = 1; k < 5; k++)
                chk("rr_spacing", 32'(grant_cyc[k] - grant_cyc[k-1]), 32'(L + 3));
        end
        wait_drain("rr_drain");

        // Backpressure: result held while another requester waits.
        @(posedge clock);
        #1;
        resp_ready = 1'b0;
        drive_req(3, 32'd50, 32'd6);
        wait_grant(3, "bp_grant");
        wait_resp(n, "bp_resp");
        hq  = resp_q;
        hr  = resp_r;
        hid = 32'(resp_id);
        hdz = 32'(resp_dz);
        chk("bp_q", hq, 32'd8);
        chk("bp_r", hr, 32'd2);
        @(posedge clock);
        #1;
        drive_req(1, 32'd9, 32'd2);
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            chk("bp_valid_held", 32'(resp_valid), 32'd1);
            chk("bp_q_held", resp_q, hq);
            chk("bp_r_held", resp_r, hr);
            chk("bp_id_held", 32'(resp_id), hid);
            chk("bp_dz_held", 32'(resp_dz), hdz);
            chk("bp_no_grant", 32'(req_ready), 32'd0);
        end
        @(posedge clock);
        #1;
        resp_ready = 1'b1;
        wait_grant(1, "bp_next_grant");
        if (grant_log.size() > 0) chk("bp_next_id", 32'(grant_log[grant_log.size()-1]), 32'd1);
        wait_drain("bp_drain");

        // Reset during BUSY; ptr would be 2, so a reset ptr favours 0 over 3.
        @(posedge clock);
        #1;
        drive_req(1, 32'd1000, 32'd3);
        wait_grant(1, "mr_grant");
        repeat (10) @(posedge clock);
        #1;
        chk("mr_in_busy", 32'(resp_valid), 32'd0);
        reset_n = 1'b0;
        sb.delete();
        drive_req(0, 32'd5, 32'd5);
        @(posedge clock);
        @(negedge clock);
        chk_reset("mr");
        @(posedge clock);
        #1;
        req_valid = '0;
        reset_n   = 1'b1;
        grant_log.delete();
        ds_cnt = 0;
        drive_req(3, 32'd20, 32'd6);
        drive_req(0, 32'hFFFF_FFFF, 32'd16);
        wait_grant(0, "mr_new_grant");
        if (grant_log.size() > 0) chk("mr_first_grant", 32'(grant_log[0]), 32'd0);
        wait_resp(n, "mr_resp");
        chk("mr_latency", 32'(n), 32'(L + 1));
        chk("mr_q", resp_q, 32'h0FFF_FFFF);
        chk("mr_r", resp_r, 32'd15);
        chk("mr_id", 32'(resp_id), 32'd0);
        chk("mr_start_cycles", 32'(ds_cnt), 32'd1);
        wait_grant(3, "mr_second_grant");
        wait_drain("mr_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
